// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts requests, sequences one or two
// W-bit passes (LSW then MSW with chained carry) and returns a registered response.
module alu_issue_ctrl #(
    parameter int W = 8
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           REQ_VALID,
    output logic           REQ_READY,
    input  logic [3:0]     REQ_OP,
    input  logic [2*W-1:0] REQ_A,
    input  logic [2*W-1:0] REQ_B,
    input  logic           REQ_WIDE,
    input  logic           REQ_BRANCH,
    output logic [W-1:0]   ALU_A,
    output logic [W-1:0]   ALU_B,
    output logic [3:0]     ALU_OP,
    output logic           ALU_SC_IN,
    output logic           ALU_IS_BRANCH,
    input  logic [W-1:0]   ALU_OUT,
    input  logic           ALU_SC_OUT,
    input  logic           ALU_ZERO,
    input  logic           ALU_BRANCH,
    output logic           RSP_VALID,
    input  logic           RSP_READY,
    output logic [2*W-1:0] RSP_DATA,
    output logic           RSP_SC,
    output logic           RSP_ZERO,
    output logic           RSP_BRANCH
);

    typedef enum logic [1:0] {IDLE, LSW, MSW, RESP} state_t;

    state_t         state;
    logic [3:0]     op_q;
    logic [2*W-1:0] a_q;
    logic [2*W-1:0] b_q;
    logic           wide_q;
    logic           branch_q;
    logic [2*W-1:0] result_q;
    logic           carry_q;
    logic           zlo_q;
    logic           zhi_q;
    logic           br_q;

    // ALU_* are registered and loaded on the edge that enters each pass, so the
    // ALU sees stable operands for the whole LSW/MSW cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            REQ_READY     <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            wide_q        <= 1'b0;
            branch_q      <= 1'b0;
            result_q      <= '0;
            carry_q       <= 1'b0;
            zlo_q         <= 1'b0;
            zhi_q         <= 1'b0;
            br_q          <= 1'b0;
            ALU_A         <= '0;
            ALU_B         <= '0;
            ALU_OP        <= '0;
            ALU_SC_IN     <= 1'b0;
            ALU_IS_BRANCH <= 1'b0;
            RSP_VALID     <= 1'b0;
            RSP_DATA      <= '0;
            RSP_SC        <= 1'b0;
            RSP_ZERO      <= 1'b0;
            RSP_BRANCH    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    REQ_READY <= 1'b1;
                    if (REQ_VALID && REQ_READY) begin
                        op_q          <= REQ_OP;
                        a_q           <= REQ_A;
                        b_q           <= REQ_B;
                        wide_q        <= REQ_WIDE;
                        branch_q      <= REQ_BRANCH;
                        result_q      <= '0;
                        carry_q       <= 1'b0;
                        zlo_q         <= 1'b0;
                        zhi_q         <= 1'b0;
                        br_q          <= 1'b0;
                        REQ_READY     <= 1'b0;
                        ALU_A         <= REQ_A[W-1:0];
                        ALU_B         <= REQ_B[W-1:0];
                        ALU_OP        <= REQ_OP;
                        ALU_SC_IN     <= 1'b0;
                        ALU_IS_BRANCH <= REQ_BRANCH && !REQ_WIDE;
                        state         <= LSW;
                    end
                end
                LSW: begin
                    result_q[W-1:0] <= ALU_OUT;
                    carry_q         <= ALU_SC_OUT;
                    zlo_q           <= ALU_ZERO;
                    br_q            <= ALU_BRANCH;
                    if (wide_q) begin
                        ALU_A         <= a_q[2*W-1:W];
                        ALU_B         <= b_q[2*W-1:W];
                        ALU_OP        <= op_q;
                        ALU_SC_IN     <= ALU_SC_OUT;
                        ALU_IS_BRANCH <= branch_q;
                        state         <= MSW;
                    end else begin
                        ALU_A         <= '0;
                        ALU_B         <= '0;
                        ALU_OP        <= '0;
                        ALU_SC_IN     <= 1'b0;
                        ALU_IS_BRANCH <= 1'b0;
                        state         <= RESP;
                    end
                end
                MSW: begin
                    result_q[2*W-1:W] <= ALU_OUT;
                    carry_q           <= ALU_SC_OUT;
                    zhi_q             <= ALU_ZERO;
                    // Wide branch decision covers all 2W bits, which the ALU never sees at once.
                    br_q              <= branch_q && (a_q != '0);
                    ALU_A             <= '0;
                    ALU_B             <= '0;
                    ALU_OP            <= '0;
                    ALU_SC_IN         <= 1'b0;
                    ALU_IS_BRANCH     <= 1'b0;
                    state             <= RESP;
                end
                RESP: begin
                    if (!RSP_VALID) begin
                        RSP_VALID  <= 1'b1;
                        RSP_DATA   <= result_q;
                        RSP_SC     <= carry_q;
                        RSP_ZERO   <= wide_q ? (zlo_q && zhi_q) : zlo_q;
                        RSP_BRANCH <= br_q;
                    end else if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        REQ_READY <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized + directed bench for alu_issue_ctrl with a behavioural ALU stand-in
// and a full-width arithmetic reference model.
module tb_alu_issue_ctrl;

    localparam int W = 8;
    localparam logic [3:0] KADD = 4'd1;
    localparam logic [3:0] KSUB = 4'd2;
    localparam logic [3:0] KAND = 4'd3;
    localparam logic [3:0] KOR  = 4'd4;
    localparam logic [3:0] KXOR = 4'd5;

    logic           CLK;
    logic           RESET_N;
    logic           REQ_VALID;
    logic           REQ_READY;
    logic [3:0]     REQ_OP;
    logic [2*W-1:0] REQ_A;
    logic [2*W-1:0] REQ_B;
    logic           REQ_WIDE;
    logic           REQ_BRANCH;
    logic [W-1:0]   ALU_A;
    logic [W-1:0]   ALU_B;
    logic [3:0]     ALU_OP;
    logic           ALU_SC_IN;
    logic           ALU_IS_BRANCH;
    logic [W-1:0]   ALU_OUT;
    logic           ALU_SC_OUT;
    logic           ALU_ZERO;
    logic           ALU_BRANCH;
    logic           RSP_VALID;
    logic           RSP_READY;
    logic [2*W-1:0] RSP_DATA;
    logic           RSP_SC;
    logic           RSP_ZERO;
    logic           RSP_BRANCH;

    int errors = 0;
    int checks = 0;

    alu_issue_ctrl #(.W(W)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_WIDE(REQ_WIDE), .REQ_BRANCH(REQ_BRANCH),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_SC_IN(ALU_SC_IN),
        .ALU_IS_BRANCH(ALU_IS_BRANCH), .ALU_OUT(ALU_OUT), .ALU_SC_OUT(ALU_SC_OUT),
        .ALU_ZERO(ALU_ZERO), .ALU_BRANCH(ALU_BRANCH),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .RSP_SC(RSP_SC), .RSP_ZERO(RSP_ZERO), .RSP_BRANCH(RSP_BRANCH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Combinational ALU stand-in: SC is carry for add, borrow for sub.
    logic [W:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (ALU_OP)
            KADD: alu_t = {1'b0, ALU_A} + {1'b0, ALU_B} + {{W{1'b0}}, ALU_SC_IN};
            KSUB: alu_t = {1'b0, ALU_A} - {1'b0, ALU_B} - {{W{1'b0}}, ALU_SC_IN};
            KAND: alu_t = {1'b0, ALU_A & ALU_B};
            KOR:  alu_t = {1'b0, ALU_A | ALU_B};
            KXOR: alu_t = {1'b0, ALU_A ^ ALU_B};
            default: alu_t = '0;
        endcase
        ALU_OUT    = alu_t[W-1:0];
        ALU_SC_OUT = alu_t[W];
        ALU_ZERO   = (alu_t[W-1:0] == '0);
        ALU_BRANCH = ALU_IS_BRANCH && (ALU_A != '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole-operation reference: plain integer arithmetic over 8 or 16 bits.
    function automatic void ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                      input logic wide, input logic br,
                                      output logic [15:0] d, output logic sc, output logic z,
                                      output logic bo, output logic lsc);
        int unsigned n, mask, am, bm, r;
        n    = wide ? 16 : 8;
        mask = (1 << n) - 1;
        am   = a & mask;
        bm   = b & mask;
        r    = 0;
        sc   = 1'b0;
        lsc  = 1'b0;
        case (op)
            KADD: begin
                r   = am + bm;
                sc  = ((r >> n) & 1) != 0;
                lsc = ((a & 16'hFF) + (b & 16'hFF)) > 255;
            end
            KSUB: begin
                r   = am - bm;
                sc  = am < bm;
                lsc = (a & 16'hFF) < (b & 16'hFF);
            end
            KAND: r = am & bm;
            KOR:  r = am | bm;
            KXOR: r = am ^ bm;
            default: r = 0;
        endcase
        d  = 16'(r & mask);
        z  = (d == 16'h0);
        bo = br && (am != 0);
    endfunction

    task automatic run_txn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic wide, input logic br, input int stall);
        logic [15:0] ed;
        logic esc, ez, eb, elsc;
        int lat, n;
        ref_model(op, a, b, wide, br, ed, esc, ez, eb, elsc);
        lat = wide ? 3 : 2;
        n = 0;
        while (!REQ_READY && n < 10) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) begin
            check("req_ready_wait", 32'(REQ_READY), 32'd1);
            return;
        end
        REQ_VALID  = 1'b1;
        REQ_OP     = op;
        REQ_A      = a;
        REQ_B      = b;
        REQ_WIDE   = wide;
        REQ_BRANCH = br;
        RSP_READY  = (stall == 0);
        @(posedge CLK);
        for (int k = 1; k <= lat; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                // Scramble request fields: in-flight operation must be unaffected.
                REQ_VALID  = 1'b0;
                REQ_OP     = 4'($urandom);
                REQ_A      = 16'($urandom);
                REQ_B      = 16'($urandom);
                REQ_WIDE   = 1'($urandom);
                REQ_BRANCH = 1'($urandom);
                check("lsw_alu_a", 32'(ALU_A), 32'(a[7:0]));
                check("lsw_alu_b", 32'(ALU_B), 32'(b[7:0]));
                check("lsw_alu_op", 32'(ALU_OP), 32'(op));
                check("lsw_sc_in", 32'(ALU_SC_IN), 32'd0);
                check("lsw_is_br", 32'(ALU_IS_BRANCH), 32'(br && !wide));
            end
            if (k == 2 && wide) begin
                check("msw_alu_a", 32'(ALU_A), 32'(a[15:8]));
                check("msw_alu_b", 32'(ALU_B), 32'(b[15:8]));
                check("msw_sc_in", 32'(ALU_SC_IN), 32'(elsc));
                check("msw_is_br", 32'(ALU_IS_BRANCH), 32'(br));
            end
            check("busy_req_ready", 32'(REQ_READY), 32'd0);
            check("early_rsp_valid", 32'(RSP_VALID), 32'd0);
            @(posedge CLK);
        end
        @(negedge CLK);
        check("rsp_valid", 32'(RSP_VALID), 32'd1);
        check("rsp_data", 32'(RSP_DATA), 32'(ed));
        check("rsp_sc", 32'(RSP_SC), 32'(esc));
        check("rsp_zero", 32'(RSP_ZERO), 32'(ez));
        check("rsp_branch", 32'(RSP_BRANCH), 32'(eb));
        check("resp_alu_a", 32'(ALU_A), 32'd0);
        for (int s = 0; s < stall; s++) begin
            REQ_VALID = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            check("stall_valid", 32'(RSP_VALID), 32'd1);
            check("stall_data", 32'(RSP_DATA), 32'(ed));
            check("stall_zero", 32'(RSP_ZERO), 32'(ez));
            check("stall_req_ready", 32'(REQ_READY), 32'd0);
        end
        REQ_VALID = 1'b0;
        RSP_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("post_rsp_valid", 32'(RSP_VALID), 32'd0);
        check("post_req_ready", 32'(REQ_READY), 32'd1);
    endtask

    initial begin
        RESET_N    = 1'b0;
        REQ_VALID  = 1'b0;
        REQ_OP     = '0;
        REQ_A      = '0;
        REQ_B      = '0;
        REQ_WIDE   = 1'b0;
        REQ_BRANCH = 1'b0;
        RSP_READY  = 1'b0;

        repeat (3) begin
            @(negedge CLK);
            check("rst_req_ready", 32'(REQ_READY), 32'd0);
            check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
            check("rst_rsp_data", 32'(RSP_DATA), 32'd0);
            check("rst_alu", {ALU_A, ALU_B, ALU_OP, ALU_SC_IN, ALU_IS_BRANCH, RSP_SC, RSP_ZERO, RSP_BRANCH, 7'd0}, 32'd0);
        end
        RESET_N = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("release_req_ready", 32'(REQ_READY), 32'd1);

        run_txn(KADD, 16'h0005, 16'h0003, 1'b0, 1'b0, 0);
        run_txn(KXOR, 16'h1234, 16'h00FF, 1'b1, 1'b0, 0);
        run_txn(KADD, 16'h12FF, 16'h0001, 1'b1, 1'b0, 0);
        run_txn(KSUB, 16'h0007, 16'h0007, 1'b0, 1'b0, 5);
        run_txn(KSUB, 16'h0100, 16'h0001, 1'b1, 1'b1, 1);
        run_txn(4'd12, 16'hABCD, 16'h1111, 1'b0, 1'b1, 0);
        run_txn(KOR, 16'h0100, 16'h0000, 1'b1, 1'b1, 0);

        // Reset pulsed during the MSW pass of a wide request.
        REQ_VALID = 1'b1;
        REQ_OP    = KOR;
        REQ_A     = 16'h1234;
        REQ_B     = 16'h4321;
        REQ_WIDE  = 1'b1;
        RSP_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("pre_rst_msw_a", 32'(ALU_A), 32'h12);
        RESET_N = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
        check("midrst_req_ready", 32'(REQ_READY), 32'd0);
        check("midrst_alu_a", 32'(ALU_A), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (4) begin
            @(posedge CLK);
            @(negedge CLK);
            check("postrst_no_rsp", 32'(RSP_VALID), 32'd0);
        end
        check("postrst_idle", 32'(REQ_READY), 32'd1);
        run_txn(KAND, 16'h00F0, 16'h003C, 1'b0, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            run_txn(4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                    1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        run_txn(KADD, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 0);
        run_txn(KSUB, 16'h0000, 16'h0001, 1'b0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
